// File: rtl/lsu_pkg.sv
// Shared types and request classification for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Unsigned widths exist only for loads.
    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return !we;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LH, F3_LHU: return lo[0];
            F3_LW:         return lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LH, F3_LHU: return {lo[1], 1'b0};
            F3_LW:         return 2'b00;
            default:       return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane steering: load extract with extension, store merge into the old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = load_word[{addr_lo, 3'b000} +: 8];
        ld_half   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        load_data = 32'd0;
        case (funct3)
            F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            F3_LW:   load_data = load_word;
            F3_LBU:  load_data = {24'd0, ld_byte};
            F3_LHU:  load_data = {16'd0, ld_half};
            default: load_data = 32'd0;
        endcase
    end

    // Untouched lanes keep the value read back in RD.
    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_LB: store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            F3_LH: begin
                if (addr_lo[1])
                    store_word[31:16] = store_data[15:0];
                else
                    store_word[15:0] = store_data[15:0];
            end
            F3_LW:   store_word = store_data;
            default: store_word = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a single-word data memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses error out instead of being aligned down.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_t state, next_state;

    logic                 lat_we;
    logic [2:0]           lat_f3;
    logic [MEM_IDX_W-1:0] lat_idx;
    logic [1:0]           lat_lo;
    logic [31:0]          lat_wdata;
    logic                 lat_err;
    logic [31:0]          rd_word;
    logic [31:0]          rdata_q;

    logic                 accept;
    logic                 req_err;
    logic [1:0]           req_lo;
    logic [31:0]          load_data;
    logic [31:0]          store_word;
    logic                 unused_addr_bits;

    assign accept = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = !lsu_f3_legal(req_we, req_funct3) || lsu_misaligned(req_funct3, req_addr[1:0]);
    assign req_lo  = req_addr[1:0];
`else
    assign req_err = !lsu_f3_legal(req_we, req_funct3);
    assign req_lo  = lsu_align_lo(req_funct3, req_addr[1:0]);
`endif

    assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Full-word stores skip the read; errors skip memory entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = RESP;
                    else if (req_we && (req_funct3 == F3_LW))
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:      next_state = lat_we ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_idx   <= '0;
            lat_lo    <= 2'd0;
            lat_wdata <= 32'd0;
            lat_err   <= 1'b0;
            rd_word   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_idx   <= req_addr[MEM_IDX_W+1:2];
                lat_lo    <= req_lo;
                lat_wdata <= req_wdata;
                lat_err   <= req_err;
                if (req_err)
                    rdata_q <= 32'd0;
            end
            if (state == RD) begin
                rd_word <= mem_read_data;
                if (!lat_we)
                    rdata_q <= load_data;
            end
            if (state == WR)
                rdata_q <= 32'd0;
        end
    end

    lsu_lane_align u_align (
        .funct3     (lat_f3),
        .addr_lo    (lat_lo),
        .load_word  (mem_read_data),
        .old_word   (rd_word),
        .store_data (lat_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESP);
    assign resp_err        = (state == RESP) && lat_err;
    assign resp_rdata      = rdata_q;
    assign mem_write_en    = (state == WR);
    assign mem_write_data  = (state == WR) ? store_word : 32'd0;
    assign mem_access_addr = {{(ADDR_W-MEM_IDX_W){1'b0}}, lat_idx};

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that initiates accesses to the word-organised data memory on behalf of the pipeline's MEM stage.
- Memory port is single-word: combinational read, write on posedge when the write enable is high.
- Converts RV32 byte/halfword/word loads and stores into word accesses. Sub-word stores use read-modify-write. Loads are sign/zero-extended.
- Sits between the execute/MEM stage and data_mem-compatible storage.

Parameters:
- ADDR_W, 32, width of byte address from pipeline and of memory address port
- MEM_IDX_W, 16, number of low word-index bits driven meaningfully on mem_access_addr; upper bits driven 0

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid
- mem_write_en  out  1  memory write strobe
- mem_access_addr  out  32  word index = byte address >> 2, bits above MEM_IDX_W forced 0
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read of mem_access_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_write_en=0, mem_access_addr=0, mem_write_data=0.
  - All captured registers cleared.
- Accept: at the posedge with req_valid && req_ready, latch we/funct3/addr/wdata. req_ready drops the next cycle.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RD on accepted load or sub-word store.
  - IDLE -> WR on accepted SW.
  - IDLE -> RESP on an error request; no memory access is made.
  - RD: drive mem_access_addr from the latched address; capture mem_read_data at the end of the cycle. Load -> RESP; sub-word store -> WR.
  - WR: mem_write_en=1 for exactly one cycle. mem_write_data = captured word with the addressed byte/half lanes replaced from req_wdata (SB lane = addr[1:0], SH lane = addr[1]). For SW, mem_write_data = req_wdata. WR -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE. There is no response backpressure.
- Latency from accept edge to resp_valid high: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
- Load extension:
  - LB/LH: sign-extend selected lane.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- resp_rdata is held until the next RESP. It is 0 for stores and errors.
- mem_write_en is 0 in every state except WR. mem_access_addr is held stable from RD through WR.
- Errors:
  - Illegal funct3 (011, 110, 111, or any funct3 outside 000/001/010 with we=1) -> resp_err=1.
  - Misalignment handling is set by the optional feature.
- req_valid high while busy: ignored, no latch; the request must be held by the pipeline.
- rst_n asserted mid-RD/WR: immediate return to IDLE. mem_write_en drops asynchronously; no partial write is completed.
- Address wrap: byte address 0xFFFF_FFFC maps to index 0x3FFF_FFFF, truncated to MEM_IDX_W bits. No special casing.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, gives an error response in 1 cycle.
  - No memory access; resp_err=1.
- Undefined:
  - Low address bits are forced to alignment: halfword clears addr[0], word clears addr[1:0].
  - Access proceeds normally; resp_err is only for illegal funct3.

Decomposition:
- lsu_pkg:
  - funct3 localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - lsu_state_t enum {IDLE, RD, WR, RESP}.
  - Function that classifies a request as legal/illegal.
- Sub-module lsu_lane_align (combinational):
  - Load path: lane extract plus sign/zero extend.
  - Store path: lane merge of old word and new data.
- Top holds the FSM and registers only.

Test Plan:
- LW: mem[4]=0x8899AABB; load funct3=010 addr=0x10 -> mem_access_addr=4 on cycle+1; resp_valid on cycle+2 with resp_rdata=0x8899AABB, err=0.
- LB/LBU: mem[4]=0x8899AABB; addr=0x12 -> LB gives 0xFFFFFF99, LBU gives 0x00000099.
- SB read-modify-write: mem[2]=0x11223344; SB addr=0x09 wdata=0x000000EE -> one mem_write_en pulse with data 0x1122EE44; resp_valid 3 cycles after accept.
- SW: SW addr=0x0 wdata=0xDEADBEEF -> mem_write_en high exactly one cycle; no RD state; mem[0]=0xDEADBEEF.
- Misaligned LH at addr=0x3:
  - With LSU_MISALIGN_TRAP_EN: resp_err=1 next cycle, mem_write_en never high.
  - Without it: address is aligned down to 0x2 and the access completes normally.
- Reset mid-SB: rst_n low during RD -> outputs zero immediately; memory unchanged; req_ready=1 after release; back-to-back requests while busy are ignored.
